bcd_to_binary_sequencer: RTL and testbench

//  Drives the decimal-to-binary conversion ROM (digit x 10^decade bit table) and accumulates its serial

---
 rtl/conv_pkg.sv | 23 ++
 rtl/serial_full_adder.sv | 34 +++
 rtl/bcd_to_binary_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bcd_to_binary_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and digit-select helper for the
// BCD-to-binary ROM sequencer.
package conv_pkg;

  localparam int NUM_DECADES = 15;
  localparam int WORD_BITS   = 50;
  localparam int SLOT_LAST   = WORD_BITS - 1;
  localparam int DECADE_LAST = NUM_DECADES - 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADD,
    DONE
  } state_e;

  // Decade d occupies bcd[4d+3:4d].
  function automatic logic [3:0] digit_at(input logic [4*NUM_DECADES-1:0] bcd,
                                          input logic [3:0]               decade);
    return bcd[{decade, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// Bit-serial full adder: combinational sum, registered carry that can be
// cleared at the start of each decade and held when not enabled.
module serial_full_adder (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_q
);

  logic carry_d;

  assign sum = a ^ b ^ carry_q;

  always_comb begin
    carry_d = carry_q;
    if (clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = (a & b) | (a & carry_q) | (b & carry_q);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

endmodule

// File: rtl/bcd_to_binary_sequencer.sv
// Walks 15 BCD digits, reads digit x 10^decade bit-serially from the
// conversion ROM and accumulates the bits into a rotating 50-bit word.
module bcd_to_binary_sequencer
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [59:0] bcd_in,
  output logic [3:0]  rom_digit,
  output logic [3:0]  rom_decade,
  output logic [5:0]  rom_slot,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        rom_we_n,
  input  logic        rom_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [49:0] result
);

  state_e      state_q, state_d;
  logic [59:0] bcd_q, bcd_d;
  logic [3:0]  decade_q, decade_d;
  logic [3:0]  digit_q, digit_d;
  logic [5:0]  slot_q, slot_d;
  logic        rom_en_q, rom_en_d;
  logic [49:0] acc_q, acc_d;
  logic [49:0] result_q, result_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  cur_digit;
  logic        adder_clr, adder_en, adder_sum, adder_carry;

  serial_full_adder u_adder (
    .clk     (clk),
    .rst     (rst),
    .clr     (adder_clr),
    .en      (adder_en),
    .a       (acc_q[0]),
    .b       (rom_data),
    .sum     (adder_sum),
    .carry_q (adder_carry)
  );

  assign cur_digit = digit_at(bcd_q, decade_q);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    decade_d  = decade_q;
    digit_d   = digit_q;
    slot_d    = slot_q;
    rom_en_d  = rom_en_q;
    acc_d     = acc_q;
    result_d  = result_q;
    error_d   = error_q;
    adder_clr = 1'b0;
    adder_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d    = bcd_in;
          acc_d    = '0;
          result_d = '0;
          error_d  = 1'b0;
          decade_d = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (cur_digit > 4'd9) begin
          error_d = 1'b1;
          acc_d   = '0;
          state_d = DONE;
        end else if (cur_digit == 4'd0) begin
          // Digit-0 ROM rows hold no valid data; contribute nothing.
          if (decade_q == 4'(DECADE_LAST)) state_d  = DONE;
          else                             decade_d = decade_q + 4'd1;
        end else begin
          digit_d   = cur_digit;
          slot_d    = '0;
          rom_en_d  = 1'b1;
          adder_clr = 1'b1;
          state_d   = ADD;
        end
      end
      ADD: begin
        adder_en = 1'b1;
        // LSB-first add; 50 rotations bring the word back into alignment.
        acc_d    = {adder_sum, acc_q[49:1]};
        if (slot_q == 6'(SLOT_LAST)) begin
          rom_en_d = 1'b0;
          if (decade_q == 4'(DECADE_LAST)) begin
            state_d = DONE;
          end else begin
            decade_d = decade_q + 4'd1;
            state_d  = CHECK;
          end
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result, done and error all become visible in the DONE cycle.
    if (state_d == DONE) result_d = acc_d;
    busy_d = (state_d == CHECK) || (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      decade_q <= '0;
      digit_q  <= '0;
      slot_q   <= '0;
      rom_en_q <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      decade_q <= decade_d;
      digit_q  <= digit_d;
      slot_q   <= slot_d;
      rom_en_q <= rom_en_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_digit  = digit_q;
  assign rom_decade = decade_q;
  assign rom_slot   = slot_q;
  assign rom_ce_n   = ~rom_en_q;
  assign rom_oe_n   = ~rom_en_q;
  assign rom_we_n   = 1'b1;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign result     = result_q;

endmodule

// File: tb/tb_bcd_to_binary_sequencer.sv
// Scoreboard bench: a behavioural ROM answers the sequencer, stimulus pushes
// expected outcomes, and a negedge monitor pops them whenever done pulses.
module tb_bcd_to_binary_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [59:0] bcd_in;
  logic [3:0]  rom_digit;
  logic [3:0]  rom_decade;
  logic [5:0]  rom_slot;
  logic        rom_ce_n, rom_oe_n, rom_we_n;
  logic        rom_data;
  logic        busy, done, error;
  logic [49:0] result;

  always #5 clk = ~clk;

  bcd_to_binary_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bcd_in     (bcd_in),
    .rom_digit  (rom_digit),
    .rom_decade (rom_decade),
    .rom_slot   (rom_slot),
    .rom_ce_n   (rom_ce_n),
    .rom_oe_n   (rom_oe_n),
    .rom_we_n   (rom_we_n),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .result     (result)
  );

  // Behavioural conversion ROM: bit 'slot' of digit * 10^decade.
  function automatic logic rom_bit(input logic [3:0] dg, input logic [3:0] dc,
                                   input logic [5:0] sl);
    logic [63:0] v;
    v = 64'(dg);
    for (int i = 0; i < int'(dc); i++) v = v * 64'd10;
    return (sl < 6'd50) ? v[sl] : 1'b0;
  endfunction

  assign rom_data = (!rom_ce_n && !rom_oe_n) ? rom_bit(rom_digit, rom_decade, rom_slot) : 1'b0;

  typedef struct {
    logic [49:0] result;
    logic        error;
    int          rom_cycles;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: accumulates per-conversion activity, compares on done.
  int   busy_cnt = 0, rom_cnt = 0, bad_rd = 0, we_low = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; rom_cnt = 0; bad_rd = 0;
    end else begin
      if (busy) busy_cnt++;
      if (!rom_we_n) we_low++;
      if (!rom_ce_n) begin
        rom_cnt++;
        if (rom_digit == 4'd0 || rom_digit > 4'd9 || rom_oe_n) bad_rd++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result",       64'(result),   64'(mon_e.result));
          check("error",        64'(error),    64'(mon_e.error));
          check("rom_cycles",   64'(rom_cnt),  64'(mon_e.rom_cycles));
          check("busy_cycles",  64'(busy_cnt), 64'(mon_e.busy_cycles));
          check("busy_at_done", 64'(busy),     64'd0);
          check("bad_rom_read", 64'(bad_rd),   64'd0);
        end
        busy_cnt = 0; rom_cnt = 0; bad_rd = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_done"},   64'(done),       64'd0);
    check({tag, "_error"},  64'(error),      64'd0);
    check({tag, "_result"}, 64'(result),     64'd0);
    check({tag, "_digit"},  64'(rom_digit),  64'd0);
    check({tag, "_decade"}, 64'(rom_decade), 64'd0);
    check({tag, "_slot"},   64'(rom_slot),   64'd0);
    check({tag, "_ce_n"},   64'(rom_ce_n),   64'd1);
    check({tag, "_oe_n"},   64'(rom_oe_n),   64'd1);
  endtask

  // Called at #1 after a posedge with the DUT idle.
  task automatic issue(input logic [59:0] bcd, input logic [49:0] r, input logic er,
                       input int rc, input int bc);
    exp_t e;
    e.result = r; e.error = er; e.rom_cycles = rc; e.busy_cycles = bc;
    sb.push_back(e);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = ~bcd;
    check("busy_after_start",   64'(busy),   64'd1);
    check("result_cleared",     64'(result), 64'd0);
    check("error_cleared",      64'(error),  64'd0);
  endtask

  // Returns at #1 after the edge on which done rose.
  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_slot(input logic [5:0] s);
    int n = 0;
    while (!(!rom_ce_n && rom_slot == s) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("slot_wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero input: 15 CHECK cycles, ROM untouched.
    issue(60'h0, 50'h0, 1'b0, 0, 15);
    wait_done("zero");
    @(posedge clk); #1;

    issue(60'h123, 50'h7B, 1'b0, 150, 165);
    wait_done("d123");
    @(posedge clk); #1;

    issue(60'h999999999999999, 50'h38D7EA4C67FFF, 1'b0, 750, 765);
    wait_done("nines");
    @(posedge clk); #1;

    // Back-to-back, previous nonzero result must clear.
    issue(60'h1, 50'h1, 1'b0, 50, 65);
    wait_done("b2b_after_nines");
    @(posedge clk); #1;

    // Top decade only: 10^14.
    issue(60'h100000000000000, 50'h5AF3107A4000, 1'b0, 50, 65);
    wait_done("top_decade");
    @(posedge clk); #1;

    // Invalid digit in decade 2 after two valid digits.
    issue(60'hA55, 50'h0, 1'b1, 100, 103);
    wait_done("err_dec2");
    @(posedge clk); #1;

    // Back-to-back after error: error must clear.
    issue(60'h1, 50'h1, 1'b0, 50, 65);
    wait_done("b2b_after_err");
    @(posedge clk); #1;

    // Invalid digit in decade 0.
    issue(60'hF, 50'h0, 1'b1, 0, 1);
    wait_done("err_dec0");
    @(posedge clk); #1;

    // Start and bcd_in toggled mid-ADD are ignored.
    issue(60'h123, 50'h7B, 1'b0, 150, 165);
    wait_slot(6'd10);
    bcd_in = 60'h999999999999999;
    start  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done("restart_ignored");
    @(posedge clk); #1;

    // Reset at slot 25: no done, everything back to reset values.
    issue(60'h999999999999999, 50'h38D7EA4C67FFF, 1'b0, 750, 765);
    wait_slot(6'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    void'(sb.pop_back());
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("idle_after_rst_busy", 64'(busy), 64'd0);

    // Recovery after reset.
    issue(60'h42, 50'h2A, 1'b0, 100, 115);
    wait_done("after_rst");
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("we_never_low",     64'(we_low),    64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
